// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe; widths follow EXP_W/MAN_W.
// master drives operands and out_ready, slave (the multiplier) drives results and in_ready.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Parametrised FP multiplier (FTZ, RNE); accept edge N -> result after edge N+3.
// Global stall when a result is held unconsumed: every stage freezes and in_ready drops.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_pipe_if.slave io
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0]    EXP_ONE  = EW'(1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic         vld;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } in_t;

  typedef struct packed {
    logic           vld;
    logic           sign;
    logic           is_spec;
    logic           spec_inv;
    logic [W-1:0]   spec_res;
    logic [EW-1:0]  exp;
    logic [MAN_W:0] mx;
    logic [MAN_W:0] my;
  } s1_t;

  typedef struct packed {
    logic          vld;
    logic          sign;
    logic          is_spec;
    logic          spec_inv;
    logic [W-1:0]  spec_res;
    logic [EW-1:0] exp;
    logic [PW-1:0] prod;
  } s2_t;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    logic         inv;
  } out_t;

  in_t  in_d,  in_q;
  s1_t  s1_d,  s1_q;
  s2_t  s2_d,  s2_q;
  out_t out_d, out_q;

  logic stall;

  assign stall       = out_q.vld & ~io.out_ready;
  assign io.in_ready = ~stall;

  assign io.out_valid = out_q.vld;
  assign io.result    = out_q.res;
  assign io.overflow  = out_q.ovf;
  assign io.underflow = out_q.unf;
  assign io.invalid   = out_q.inv;

  // Operand capture at the accept edge.
  always_comb begin
    in_d = in_q;
    if (!stall) begin
      in_d.vld = io.in_valid;
      in_d.x   = io.x;
      in_d.y   = io.y;
    end
  end

  logic             xs, ys;
  logic [EXP_W-1:0] xe, ye;
  logic [MAN_W-1:0] xf, yf;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  assign {xs, xe, xf} = in_q.x;
  assign {ys, ye, yf} = in_q.y;

  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (xe == EXP_ONES) && (xf == '0);
  assign y_inf  = (ye == EXP_ONES) && (yf == '0);
  assign x_nan  = (xe == EXP_ONES) && (xf != '0);
  assign y_nan  = (ye == EXP_ONES) && (yf != '0);

  // S1: classify, resolve special operands up front, biased exponent sum.
  always_comb begin
    s1_d = s1_q;
    if (!stall) begin
      s1_d.vld      = in_q.vld;
      s1_d.sign     = xs ^ ys;
      s1_d.exp      = EW'(xe) + EW'(ye) - BIAS;
      s1_d.mx       = {1'b1, xf};
      s1_d.my       = {1'b1, yf};
      s1_d.is_spec  = 1'b1;
      s1_d.spec_inv = 1'b0;
      s1_d.spec_res = '0;
      if (x_nan || y_nan) begin
        s1_d.spec_res = QNAN;
      end else if ((x_zero && y_inf) || (x_inf && y_zero)) begin
        s1_d.spec_res = QNAN;
        s1_d.spec_inv = 1'b1;
      end else if (x_inf || y_inf) begin
        s1_d.spec_res = {xs ^ ys, EXP_ONES, {MAN_W{1'b0}}};
      end else if (x_zero || y_zero) begin
        s1_d.spec_res = {xs ^ ys, {(W-1){1'b0}}};
      end else begin
        s1_d.is_spec = 1'b0;
      end
    end
  end

  // S2: full mantissa product, value in [1,4) with the point above bit 2*MAN_W.
  always_comb begin
    s2_d = s2_q;
    if (!stall) begin
      s2_d.vld      = s1_q.vld;
      s2_d.sign     = s1_q.sign;
      s2_d.is_spec  = s1_q.is_spec;
      s2_d.spec_inv = s1_q.spec_inv;
      s2_d.spec_res = s1_q.spec_res;
      s2_d.exp      = s1_q.exp;
      s2_d.prod     = PW'(s1_q.mx) * PW'(s1_q.my);
    end
  end

  logic           top;
  logic [PW-2:0]  norm;
  logic [EW-1:0]  e_norm;
  logic [EW-1:0]  e_rnd;
  logic [MAN_W-1:0] frac;
  logic           guard;
  logic           sticky;
  logic           rnd;
  logic [MAN_W:0] frac_r;

  // S3: normalise (drop hidden bit), RNE, renormalise on carry, range check, pack.
  always_comb begin
    top    = s2_q.prod[PW-1];
    norm   = top ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
    e_norm = s2_q.exp + EW'(top);
    frac   = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    e_rnd  = e_norm + EW'(frac_r[MAN_W]);

    out_d = out_q;
    if (!stall) begin
      out_d = '0;
      if (s2_q.vld) begin
        out_d.vld = 1'b1;
        if (s2_q.is_spec) begin
          out_d.res = s2_q.spec_res;
          out_d.inv = s2_q.spec_inv;
        end else if ($signed(e_rnd) >= $signed(EXP_MAX)) begin
          out_d.res = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
          out_d.ovf = 1'b1;
        end else if ($signed(e_rnd) < $signed(EXP_ONE)) begin
          out_d.res = {s2_q.sign, {(W-1){1'b0}}};
          out_d.unf = 1'b1;
        end else begin
          out_d.res = {s2_q.sign, e_rnd[EXP_W-1:0], frac_r[MAN_W-1:0]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Generalises the fixed single/double add/mul unit to any exponent/mantissa width, with a valid/ready handshake, backpressure and separate exception flags.
- Sits between operand sources and result sinks in the FP datapath. One multiply is accepted per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width (8 = single, 11 = double).
- MAN_W, 23, stored fraction width (23 = single, 52 = double).
- W, EXP_W+MAN_W+1, total operand width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands x, y present.
- in_ready  output  1  pipeline can accept this cycle.
- x  input  W  operand A {sign, exp, frac}.
- y  input  W  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  sink accepts result.
- result  output  W  product.
- overflow  output  1  finite result exceeded range; result = ±Inf.
- underflow  output  1  nonzero exact result below min normal; result = ±0.
- invalid  output  1  0 × Inf operation.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits cleared.
  - out_valid=0, result=0, overflow=underflow=invalid=0.
  - in_ready=1 in the cycle after reset.
  - In-flight operations are discarded; no output appears for them.
- Pipeline: 3 register stages.
  - S1: unpack, classify, sign = xs^ys, exp sum.
  - S2: (MAN_W+1)×(MAN_W+1) mantissa product.
  - S3: normalise, round, pack, flags.
- Latency: accepted at edge N → out_valid=1 after edge N+3, provided there is no stall.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, all stages hold and result/flags are stable.
  - Bubbles are not compressed (global stall).
- Classification:
  - exp=0 → zero; subnormal inputs are flushed to zero (FTZ).
  - exp=all-ones & frac=0 → Inf.
  - exp=all-ones & frac≠0 → NaN.
- Special results, priority order:
  1. Any NaN input → canonical qNaN {0, all-ones, 1 followed by zeros}, no flag.
  2. 0×Inf → canonical qNaN, invalid=1.
  3. Inf × nonzero → ±Inf, no flag.
  4. Zero × finite → ±0 (sign = xs^ys), no flag.
- Normal path:
  - Biased exponent e = ex + ey − bias, where bias = 2^(EXP_W−1)−1.
  - Computed in EXP_W+2 signed bits.
  - Product of the 1.f mantissas lies in [1,4). If ≥2, shift right 1 and e+1.
- Rounding: round-to-nearest-even using guard bit and sticky (OR of all lower bits).
  - Rounding carry-out renormalises: frac becomes 0, e+1.
- Range checks, applied after rounding:
  - e ≥ all-ones → ±Inf, overflow=1.
  - e ≤ 0 → ±0, underflow=1 (no subnormal outputs).
- Flags are mutually exclusive and are qualified by out_valid. They are 0 when out_valid=0.
- Continuous in_valid with out_ready=1 gives one result per cycle, in input order.

Test Plan:
- Single precision (default params):
  - x=0x40000000, y=0x40400000 → result 0x40C00000, all flags 0, out_valid exactly 3 cycles after accept.
  - x=0xC0000000, y=0x40400000 → result 0xC0C00000.
- Rounding / exceptions, single precision:
  - 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE).
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
  - 0x00000000 × 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, no flags.
- Double (EXP_W=11, MAN_W=52): 0x4000000000000000 × 0x4008000000000000 → 0x4018000000000000, flags 0.
- Backpressure:
  - Stream 5 back-to-back ops (1.0×k for k=1..5).
  - Hold out_ready=0 for 4 cycles once out_valid rises.
  - Required: in_ready=0 throughout the stall; result held stable; all 5 results emerge in order with none lost or duplicated.
- Reset mid-operation:
  - Accept 2 ops, then assert rst for 1 cycle at the next edge.
  - Required: out_valid stays 0 until new ops are issued, and the first new op returns after 3 cycles.
